// File: rtl/arilla_bus_arbiter.sv
// arilla_bus_arbiter: registered round-robin arbiter that sequences NumRequesters masters onto one arilla bus.
// Optional feature: define ARILLA_BUS_ARBITER_LOCK_EN to add req_lock, which lets the current owner keep the bus.
module arilla_bus_arbiter #(
  parameter int NumRequesters     = 2,
  parameter int DataWidth         = 32,
  parameter int ByteAddressWidth  = 32,
  parameter int ByteSize          = 8,
  parameter int ReadLatency       = 1,
  localparam int BytesPerWord     = DataWidth / ByteSize,
  localparam int WordAddressWidth = ByteAddressWidth - $clog2(BytesPerWord)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NumRequesters-1:0]               req_read,
  input  logic [NumRequesters-1:0]               req_write,
  input  logic [NumRequesters*WordAddressWidth-1:0] req_address,
  input  logic [NumRequesters*BytesPerWord-1:0]  req_byte_enable,
  input  logic [NumRequesters*DataWidth-1:0]     req_data,
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
  input  logic [NumRequesters-1:0]               req_lock,
`endif
  input  logic                                   inhibit,
  output logic [NumRequesters-1:0]               rsp_valid,
  output logic [DataWidth-1:0]                   rsp_data,
  output logic                                   rsp_hit,
  output logic [WordAddressWidth-1:0]            bus_address,
  output logic [BytesPerWord-1:0]                bus_byte_enable,
  output logic [DataWidth-1:0]                   bus_data_ctp,
  output logic                                   bus_read,
  output logic                                   bus_write,
  input  logic [DataWidth-1:0]                   bus_data_ptc,
  input  logic                                   bus_hit
);
  localparam int IdxWidth = NumRequesters > 1 ? $clog2(NumRequesters) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESPOND} state_e;
  state_e state_q, state_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d, owner_q, owner_d, win, idx;
  logic [3:0] cnt_q, cnt_d;
  logic found;
  logic [NumRequesters-1:0] eligible, owner_onehot, rsp_valid_q, rsp_valid_d;
  logic [WordAddressWidth-1:0] bus_address_q, bus_address_d;
  logic [BytesPerWord-1:0] bus_byte_enable_q, bus_byte_enable_d;
  logic [DataWidth-1:0] bus_data_ctp_q, bus_data_ctp_d, rsp_data_q, rsp_data_d;
  logic bus_read_q, bus_read_d, bus_write_q, bus_write_d, rsp_hit_q, rsp_hit_d;
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
  logic lock_q, lock_d;
`endif

  assign eligible     = (req_read | req_write) & ~NumRequesters'(inhibit);
  assign owner_onehot = NumRequesters'(1) << owner_q;

  // Winner search ascending from the pointer with wrap; a locked owner that is still eligible takes precedence
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      idx = IdxWidth'((int'(ptr_q) + k) % NumRequesters);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
    if (lock_q && eligible[owner_q]) begin
      found = 1'b1;
      win   = owner_q;
    end
`endif
  end

  // Access sequencer: grant and register the address phase, strobe once, wait out the read latency, respond
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    owner_d           = owner_q;
    cnt_d             = cnt_q;
    bus_address_d     = bus_address_q;
    bus_byte_enable_d = bus_byte_enable_q;
    bus_data_ctp_d    = bus_data_ctp_q;
    bus_read_d        = 1'b0;
    bus_write_d       = 1'b0;
    rsp_valid_d       = '0;
    rsp_data_d        = rsp_data_q;
    rsp_hit_d         = rsp_hit_q;
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
    lock_d            = lock_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d           = ACCESS;
        owner_d           = win;
        ptr_d             = (int'(win) == NumRequesters - 1) ? '0 : win + 1'b1;
        bus_address_d     = req_address[win*WordAddressWidth +: WordAddressWidth];
        bus_byte_enable_d = req_byte_enable[win*BytesPerWord +: BytesPerWord];
        bus_data_ctp_d    = req_data[win*DataWidth +: DataWidth];
        bus_write_d       = req_write[win];
        bus_read_d        = ~req_write[win];
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
        lock_d            = 1'b0;
`endif
      end
      ACCESS: if (bus_write_q || ReadLatency == 0) begin
        rsp_data_d  = bus_write_q ? '0 : bus_data_ptc;
        rsp_hit_d   = bus_hit;
        rsp_valid_d = owner_onehot;
        state_d     = RESPOND;
      end else begin
        cnt_d   = 4'(ReadLatency - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        rsp_data_d  = bus_data_ptc;
        rsp_hit_d   = bus_hit;
        rsp_valid_d = owner_onehot;
        state_d     = RESPOND;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESPOND: begin
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
        lock_d  = req_lock[owner_q];
`endif
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      ptr_q             <= '0;
      owner_q           <= '0;
      cnt_q             <= '0;
      bus_address_q     <= '0;
      bus_byte_enable_q <= '0;
      bus_data_ctp_q    <= '0;
      bus_read_q        <= 1'b0;
      bus_write_q       <= 1'b0;
      rsp_valid_q       <= '0;
      rsp_data_q        <= '0;
      rsp_hit_q         <= 1'b0;
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
      lock_q            <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      owner_q           <= owner_d;
      cnt_q             <= cnt_d;
      bus_address_q     <= bus_address_d;
      bus_byte_enable_q <= bus_byte_enable_d;
      bus_data_ctp_q    <= bus_data_ctp_d;
      bus_read_q        <= bus_read_d;
      bus_write_q       <= bus_write_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      rsp_hit_q         <= rsp_hit_d;
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
      lock_q            <= lock_d;
`endif
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_hit         = rsp_hit_q;
  assign bus_address     = bus_address_q;
  assign bus_byte_enable = bus_byte_enable_q;
  assign bus_data_ctp    = bus_data_ctp_q;
  assign bus_read        = bus_read_q;
  assign bus_write       = bus_write_q;
endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb_arilla_bus_arbiter: randomized and directed bench checking the arbiter against a transaction timeline model.
module tb_arilla_bus_arbiter;
  localparam int N = 2, DW = 32, BPW = 4, AW = 30, RL = 1;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_read = '0, req_write = '0, rsp_valid;
  logic [N*AW-1:0] req_address = '0;
  logic [N*BPW-1:0] req_byte_enable = '0;
  logic [N*DW-1:0] req_data = '0;
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
  logic [N-1:0] req_lock = '0;
`endif
  logic inhibit = 1'b0, rsp_hit, bus_read, bus_write, bus_hit = 1'b0;
  logic [DW-1:0] rsp_data, bus_data_ctp, bus_data_ptc = '0;
  logic [AW-1:0] bus_address;
  logic [BPW-1:0] bus_byte_enable;

  always #5 clk = ~clk;

  arilla_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_byte_enable(req_byte_enable), .req_data(req_data),
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .inhibit(inhibit), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .bus_address(bus_address), .bus_byte_enable(bus_byte_enable), .bus_data_ctp(bus_data_ctp),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_ptc(bus_data_ptc), .bus_hit(bus_hit)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, mode = 0;
  bit inh_set = 0, single_go = 0;
  logic [AW-1:0] a_s[N];
  logic [BPW-1:0] be_s[N];
  logic [DW-1:0] d_s[N];
  bit pend[N], isw[N];
  int free_cyc, strobe_cyc, cap_cyc, rsp_cyc, rr, own;
  bit m_wr, lock_own;
  logic [AW-1:0] e_addr;
  logic [BPW-1:0] e_be;
  logic [DW-1:0] e_dctp, e_rdata;
  logic e_hit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ev;
    ev = (cyc == rsp_cyc) ? (N'(1) << own) : '0;
    chk("rsp_valid", rsp_valid, ev);
    chk("bus_read", bus_read, (cyc == strobe_cyc) && !m_wr);
    chk("bus_write", bus_write, (cyc == strobe_cyc) && m_wr);
    chk("bus_address", bus_address, e_addr);
    chk("bus_byte_enable", bus_byte_enable, e_be);
    chk("bus_data_ctp", bus_data_ctp, e_dctp);
    chk("rsp_data", rsp_data, e_rdata);
    chk("rsp_hit", rsp_hit, e_hit);
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_read[i]  = pend[i] && !isw[i];
      req_write[i] = pend[i] && isw[i];
      req_address[i*AW +: AW]    = a_s[i];
      req_byte_enable[i*BPW +: BPW] = be_s[i];
      req_data[i*DW +: DW]       = d_s[i];
      assert (!(req_read[i] && req_write[i]));
    end
  endtask

  task automatic start(input int i, input bit wr, input logic [AW-1:0] a);
    pend[i] = 1; isw[i] = wr; a_s[i] = a;
    be_s[i] = BPW'($urandom); d_s[i] = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pend[i] && rsp_valid[i]) pend[i] = 0;
      if (!pend[i]) begin
        if (mode == 1 && $urandom_range(0, 2) == 0) start(i, 1'($urandom_range(0, 1)), AW'($urandom));
        else if (mode == 2) start(i, 1'b1, AW'($urandom));
        else if (mode == 3 && i == 1 && single_go) begin start(1, 1'b0, 30'h10); single_go = 0; end
      end
    end
    pack_inputs();
    inhibit      = (mode == 1) ? ($urandom_range(0, 3) == 0) : inh_set;
    bus_data_ptc = (mode == 3) ? 32'hDEADBEEF : $urandom;
    bus_hit      = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
    req_lock = (mode == 1) ? N'($urandom) : '0;
`endif
  endtask

  task automatic model_eval();
    int w;
    bit el[N];
    if (cyc == cap_cyc) begin e_rdata = m_wr ? '0 : bus_data_ptc; e_hit = bus_hit; end
`ifdef ARILLA_BUS_ARBITER_LOCK_EN
    if (cyc == rsp_cyc) lock_own = req_lock[own];
`endif
    if (cyc == free_cyc) begin
      w = -1;
      for (int i = 0; i < N; i++) el[i] = (req_read[i] || req_write[i]) && !(i == 0 && inhibit);
      if (lock_own && el[own]) w = own;
      for (int k = 0; k < N; k++) if (w < 0 && el[(rr + k) % N]) w = (rr + k) % N;
      if (w < 0) free_cyc = cyc + 1;
      else begin
        own = w; rr = (w + 1) % N; lock_own = 0; m_wr = req_write[w];
        e_addr = req_address[w*AW +: AW]; e_be = req_byte_enable[w*BPW +: BPW]; e_dctp = req_data[w*DW +: DW];
        strobe_cyc = cyc + 1;
        cap_cyc    = m_wr ? strobe_cyc : strobe_cyc + RL;
        rsp_cyc    = cap_cyc + 1;
        free_cyc   = rsp_cyc + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
    drive();
    model_eval();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    pack_inputs();
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_bus_read", bus_read, 0);
    chk("reset_bus_write", bus_write, 0);
    chk("reset_bus_address", bus_address, 0);
    chk("reset_bus_data_ctp", bus_data_ctp, 0);
    chk("reset_rsp_data", rsp_data, 0);
    repeat (2) begin @(negedge clk); cyc++; end
    rst_n = 1'b1;
    rr = 0; own = 0; lock_own = 0; m_wr = 0;
    strobe_cyc = -1; cap_cyc = -1; rsp_cyc = -1; free_cyc = cyc + 1;
    e_addr = '0; e_be = '0; e_dctp = '0; e_rdata = '0; e_hit = 1'b0;
  endtask

  initial begin
    int t_rd, t_rsp, cnt0, cnt_all, first0;
    int own_q[$], cyc_q[$];
    #1;
    do_reset();

    // Single read from requester 1
    mode = 3; single_go = 1; t_rd = -1; t_rsp = -1;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (bus_read && t_rd < 0) t_rd = t;
      if (rsp_valid[1] && t_rsp < 0) begin
        t_rsp = t;
        chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("single_rsp_hit", rsp_hit, 1);
      end
    end
    chk("single_strobe_cycle", t_rd, 2);
    chk("single_rsp_cycle", t_rsp, 4);
    chk("single_address", bus_address, 30'h10);

    // Contention from reset: both requesters write continuously
    do_reset();
    mode = 2;
    repeat (24) begin
      step();
      if (rsp_valid != '0) begin own_q.push_back(rsp_valid[1] ? 1 : 0); cyc_q.push_back(cyc); end
    end
    chk("contention_pulses", own_q.size() >= 6, 1);
    for (int k = 0; k < 4 && k + 1 < own_q.size(); k++) begin
      chk("contention_owner", own_q[k], k % 2);
      chk("contention_gap", cyc_q[k+1] - cyc_q[k], 3);
    end

    // Inhibit blocks requester 0, release lets it in next
    mode = 0; repeat (8) step();
    inh_set = 1; mode = 2; cnt0 = 0; cnt_all = 0;
    repeat (15) begin
      step();
      if (rsp_valid != '0) begin cnt_all++; if (rsp_valid[0]) cnt0++; end
    end
    chk("inhibit_no_core_grant", cnt0, 0);
    chk("inhibit_req1_served", cnt_all >= 3, 1);
    inh_set = 0; cnt_all = 0; first0 = -1;
    repeat (15) begin
      step();
      if (rsp_valid != '0) begin
        if (rsp_valid[0] && first0 < 0) first0 = cnt_all;
        cnt_all++;
      end
    end
    chk("inhibit_release_core_next", (first0 >= 0) && (first0 <= 1), 1);

    // Randomized traffic with random inhibit
    do_reset();
    mode = 1;
    repeat (3000) step();

    // Reset during WAIT drops the access
    mode = 0; repeat (8) step();
    mode = 3; single_go = 1; t_rd = -1;
    for (int t = 1; t <= 10 && t_rd < 0; t++) begin
      step();
      if (bus_read) t_rd = t;
    end
    chk("wait_reset_strobe_seen", t_rd > 0, 1);
    step();
    mode = 0;
    do_reset();
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
